// File: rtl/sfq_split_pulse_scheduler_pkg.sv
// Shared defaults, grant index type and a reference round-robin pick for the
// SFQ split-pulse scheduler.
package sfq_sched_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_CNT_W     = 3;
  localparam int DEF_CT_CYCLES = 7;

  typedef logic [$clog2(DEF_N_REQ)-1:0] grant_idx_t;

  // Up to 8 requesters; first set bit at or above ptr, wrapping. Returns 0 on empty mask.
  function automatic logic [2:0] rr_pick(input logic [7:0] mask, input logic [2:0] ptr,
                                         input int n);
    logic [2:0] j;
    rr_pick = '0;
    for (int k = n - 1; k >= 0; k--) begin
      j = 3'((int'(ptr) + k) % n);
      if (mask[j]) rr_pick = j;
    end
  endfunction

endpackage

// File: rtl/sfq_split_pulse_scheduler_arbiter.sv
// Combinational rotate-priority arbiter: first set mask bit at or above i_ptr,
// wrapping modulo N.
module sfq_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_mask,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  localparam int SW = IDX_W + 1;
  localparam logic [SW-1:0] N_L = SW'(N);

  logic [SW-1:0]    w_sum;
  logic [IDX_W-1:0] w_j;
  logic             w_found;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_j      = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + SW'(k);
      if (w_sum >= N_L) w_sum = w_sum - N_L;
      w_j = w_sum[IDX_W-1:0];
      if (!w_found && i_mask[w_j]) begin
        w_found     = 1'b1;
        o_onehot[w_j] = 1'b1;
        o_idx       = w_j;
      end
    end
  end

  assign o_any = |i_mask;

endmodule

// File: rtl/sfq_split_pulse_scheduler.sv
// Shares one toggle-encoded SFQ line among N_REQ requesters: per-requester pulse
// queues, round-robin issue, and a guard interval between successive pulses.
module sfq_split_pulse_scheduler
  import sfq_sched_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int CT_CYCLES = DEF_CT_CYCLES,
  localparam int IDX_W    = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req_valid,
  output logic [N_REQ-1:0] o_req_ready,
  input  logic             i_hold,
  output logic             o_sfq_a,
  output logic             o_grant_valid,
  output logic [IDX_W-1:0] o_grant_id,
  output logic             o_guard_busy,
  output logic             o_pending_any
);

  localparam int GRD_W = $clog2(CT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt [N_REQ];
  logic             r_sfq_a;
  logic             r_grant_valid;
  logic [IDX_W-1:0] r_grant_id;
  logic [IDX_W-1:0] r_ptr;
  logic [GRD_W-1:0] r_guard;

  logic [N_REQ-1:0] w_nz;
  logic [N_REQ-1:0] w_inc;
  logic [N_REQ-1:0] w_dec;
  logic [N_REQ-1:0] w_win_oh;
  logic [IDX_W-1:0] w_win_idx;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic             w_win_any;
  logic             w_guard_busy;
  logic             w_issue;

  always_comb begin
    w_nz        = '0;
    o_req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_nz[i]        = (r_cnt[i] != '0);
      o_req_ready[i] = (r_cnt[i] != CNT_MAX);
    end
  end

  sfq_rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_arb (
    .i_mask  (w_nz),
    .i_ptr   (r_ptr),
    .o_onehot(w_win_oh),
    .o_idx   (w_win_idx),
    .o_any   (w_win_any)
  );

  assign w_guard_busy = (r_guard != '0);
  assign w_issue      = !i_hold && !w_guard_busy && w_win_any;
  assign w_inc        = i_req_valid & o_req_ready;
  assign w_dec        = w_win_oh & {N_REQ{w_issue}};
  assign w_ptr_nxt    = (w_win_idx == IDX_W'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
      r_sfq_a       <= 1'b0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_ptr         <= '0;
      r_guard       <= '0;
    end else begin
      // Accept and issue on the same requester cancel out.
      for (int i = 0; i < N_REQ; i++) begin
        if (w_inc[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
      r_grant_valid <= w_issue;
      if (w_issue) begin
        r_sfq_a    <= ~r_sfq_a;
        r_grant_id <= w_win_idx;
        r_ptr      <= w_ptr_nxt;
        r_guard    <= GRD_W'(CT_CYCLES - 1);
      end else if (w_guard_busy) begin
        r_guard <= r_guard - 1'b1;
      end
    end
  end

  assign o_sfq_a       = r_sfq_a;
  assign o_grant_valid = r_grant_valid;
  assign o_grant_id    = r_grant_id;
  assign o_guard_busy  = w_guard_busy;
  assign o_pending_any = |w_nz;

endmodule
